// File: rtl/target_board.sv
// target_board: battleship-style target selector.
// Holds a 16-cell ship map, debounces a raw fire button, latches the aimed
// cell, and issues a one-cycle shot (or repeat) pulse to the gunner stage
// while keeping shot / remaining-ship tallies until the board is cleared.
module target_board #(
  parameter int DB_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        LOAD,
  input  logic [15:0] MAPIN,
  input  logic [1:0]  ROWSEL,
  input  logic [1:0]  COLSEL,
  input  logic        BTNRAW,
  output logic        IPTSHIP,
  output logic        BTNIPT,
  output logic        CLR,
  output logic        REPEAT,
  output logic [4:0]  SHOTCNT,
  output logic [4:0]  SHIPSLEFT,
  output logic        DONE
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ARMED        = 3'd1;
  localparam logic [2:0] DEBOUNCE     = 3'd2;
  localparam logic [2:0] FIRE         = 3'd3;
  localparam logic [2:0] WAIT_RELEASE = 3'd4;
  localparam logic [2:0] OVER         = 3'd5;

  // Counter value on the cycle that completes a debounce window.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic        bs_meta, bs;
  logic [2:0]  state, state_nxt;
  logic [7:0]  db_cnt, db_cnt_nxt;
  logic [15:0] map_q, fired_q;
  logic [3:0]  tgt;
  logic        clr_q;
  logic [4:0]  shotcnt_q, shipsleft_q;

  logic in_fire, tgt_fired, tgt_ship, fresh, last_hit, capture, commit;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Two-flop synchronizer on the raw button; only bs is used downstream.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      bs_meta <= 1'b0;
      bs      <= 1'b0;
    end else begin
      bs_meta <= BTNRAW;
      bs      <= bs_meta;
    end
  end

  // Shot decode is purely from registered state, map, mask and target.
  assign in_fire   = (state == FIRE);
  assign tgt_fired = fired_q[tgt];
  assign tgt_ship  = map_q[tgt];
  assign fresh     = in_fire & ~tgt_fired;
  assign last_hit  = fresh & tgt_ship & (shipsleft_q == 5'd1);

  // A load on the same edge wins over both target capture and shot commit.
  assign capture = (state == DEBOUNCE) & bs & (db_cnt == DB_LAST) & ~LOAD;
  assign commit  = fresh & ~LOAD;

  // Next-state and debounce counter; LOAD overrides every transition.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    case (state)
      IDLE: ;
      ARMED: begin
        if (bs) begin
          state_nxt  = DEBOUNCE;
          db_cnt_nxt = '0;
        end
      end
      DEBOUNCE: begin
        if (!bs)                    state_nxt  = ARMED;
        else if (db_cnt == DB_LAST) state_nxt  = FIRE;
        else                        db_cnt_nxt = db_cnt + 8'd1;
      end
      FIRE: begin
        state_nxt  = last_hit ? OVER : WAIT_RELEASE;
        db_cnt_nxt = '0;
      end
      WAIT_RELEASE: begin
        if (bs)                     db_cnt_nxt = '0;
        else if (db_cnt == DB_LAST) state_nxt  = ARMED;
        else                        db_cnt_nxt = db_cnt + 8'd1;
      end
      OVER: ;
      default: state_nxt = IDLE;
    endcase
    if (LOAD) begin
      state_nxt  = (MAPIN == 16'h0000) ? OVER : WAIT_RELEASE;
      db_cnt_nxt = '0;
    end
  end

  // State and debounce counter registers.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Target latch: cursor is frozen at the edge that enters FIRE.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)        tgt <= '0;
    else if (capture) tgt <= {ROWSEL, COLSEL};
  end

  // Board contents and tallies: reloaded on LOAD, updated when a fresh shot retires.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      map_q       <= '0;
      fired_q     <= '0;
      shotcnt_q   <= '0;
      shipsleft_q <= '0;
    end else if (LOAD) begin
      map_q       <= MAPIN;
      fired_q     <= '0;
      shotcnt_q   <= '0;
      shipsleft_q <= popcount16(MAPIN);
    end else if (commit) begin
      fired_q[tgt] <= 1'b1;
      shotcnt_q    <= shotcnt_q + 5'd1;
      if (tgt_ship) shipsleft_q <= shipsleft_q - 5'd1;
    end
  end

  // One-cycle clear pulse following each load.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) clr_q <= 1'b0;
    else       clr_q <= LOAD;
  end

  assign BTNIPT    = fresh;
  assign IPTSHIP   = fresh & tgt_ship;
  assign REPEAT    = in_fire & tgt_fired;
  assign CLR       = clr_q;
  assign SHOTCNT   = shotcnt_q;
  assign SHIPSLEFT = shipsleft_q;
  assign DONE      = (state == OVER);

endmodule

// File: doc/target_board.md
TARGET_BOARD -- requirements
Module: target_board

Interface
REQ-001 Parameter: DB_CYCLES, 4, consecutive synchronized-high cycles required to accept a fire press (1..255).
REQ-002 CLK  in  1  single system clock, all state updates on rising edge.
REQ-003 NRST  in  1  asynchronous, active-low reset.
REQ-004 LOAD  in  1  synchronous load strobe for a new ship map.
REQ-005 MAPIN  in  16  ship map, bit i = 1 means ship in cell i, i = ROWSEL*4+COLSEL.
REQ-006 ROWSEL  in  2  target row.
REQ-007 COLSEL  in  2  target column.
REQ-008 BTNRAW  in  1  raw asynchronous fire button, active high, may bounce.
REQ-009 IPTSHIP  out  1  target cell holds a ship; valid in the BTNIPT cycle.
REQ-010 BTNIPT  out  1  one-cycle accepted-shot pulse to the downstream gunner stage.
REQ-011 CLR  out  1  one-cycle clear pulse on load, drives the gunner's LED clear input.
REQ-012 REPEAT  out  1  one-cycle pulse: accepted press on an already-fired cell.
REQ-013 SHOTCNT  out  5  fresh shots fired since load (0..16).
REQ-014 SHIPSLEFT  out  5  unhit ship cells remaining (0..16).
REQ-015 DONE  out  1  high while all ship cells are hit.

Function
REQ-016 BTNRAW SHALL pass a two-flop synchronizer before any use; only the synchronized value (BS) is referenced below.
REQ-017 FSM states SHALL be IDLE, ARMED, DEBOUNCE, FIRE, WAIT_RELEASE, OVER.
REQ-018 IDLE: BS ignored; exits only on LOAD.
REQ-019 ARMED: BS=1 -> DEBOUNCE with debounce counter cleared.
REQ-020 DEBOUNCE: counter increments each cycle BS=1; BS=0 -> ARMED; counter reaching DB_CYCLES -> FIRE, capturing ROWSEL/COLSEL into target register TGT on that same edge.
REQ-021 FIRE lasts exactly one cycle, then -> WAIT_RELEASE, or -> OVER if SHIPSLEFT becomes 0.
REQ-022 In FIRE with fired-mask bit TGT = 0: BTNIPT=1, IPTSHIP=map[TGT], REPEAT=0; on exit edge set fired-mask bit TGT, SHOTCNT+1, and SHIPSLEFT-1 if map[TGT]=1.
REQ-023 In FIRE with fired-mask bit TGT = 1: REPEAT=1, BTNIPT=0, IPTSHIP=0, counters unchanged.
REQ-024 IPTSHIP, BTNIPT, REPEAT SHALL be 0 outside FIRE and SHALL be decoded from registers only (no combinational path from any input).
REQ-025 WAIT_RELEASE: -> ARMED after BS=0 for DB_CYCLES consecutive cycles; any BS=1 restarts the count.
REQ-026 OVER: DONE=1, all presses ignored, exits only on LOAD or reset.
REQ-027 LOAD=1 in any state SHALL, on that edge: map<=MAPIN, fired mask<=0, SHOTCNT<=0, SHIPSLEFT<=popcount(MAPIN), CLR=1 next cycle for one cycle, state<=WAIT_RELEASE, or OVER if MAPIN=0.
REQ-028 LOAD SHALL take priority over every FSM transition in the same cycle, including a pending FIRE commit (that shot is discarded).
REQ-029 SHOTCNT and SHIPSLEFT never wrap; the fired mask guarantees SHOTCNT<=16 and SHIPSLEFT>=0.
REQ-030 ROWSEL/COLSEL changes after TGT capture SHALL NOT affect the shot in progress.
REQ-031 DONE = (state==OVER), registered.

Reset
REQ-032 NRST=0 SHALL immediately force state IDLE, map, fired mask, TGT, debounce counter, synchronizer flops, SHOTCNT, SHIPSLEFT to 0; all outputs 0.
REQ-033 Reset release with BTNRAW held high SHALL NOT produce BTNIPT or REPEAT.
REQ-034 Reset asserted mid-DEBOUNCE or in FIRE SHALL discard the shot; no counter update.

Verification
REQ-035 Reset, LOAD MAPIN=16'h0001 -> CLR pulse, SHIPSLEFT=1, SHOTCNT=0, DONE=0; BTNIPT never seen before a press.
REQ-036 Cursor (0,1), clean press 10 cycles -> single BTNIPT, IPTSHIP=0, SHOTCNT=1, SHIPSLEFT=1; press 2 cycles only -> no pulse.
REQ-037 Cursor (0,0), press -> BTNIPT with IPTSHIP=1, SHIPSLEFT=0, DONE=1 next cycle; further presses -> no pulses.
REQ-038 Reload MAPIN=16'h8001, fire cell 15 twice -> first BTNIPT/IPTSHIP=1, second REPEAT=1 only; SHOTCNT=1, SHIPSLEFT=1.
REQ-039 Bouncing BTNRAW (toggle every cycle 6 cycles, then steady high) -> exactly one BTNIPT; cursor changed during FIRE -> shot uses captured cell.
REQ-040 LOAD in same cycle as DEBOUNCE->FIRE -> no BTNIPT, counters = load values; NRST pulsed mid-DEBOUNCE -> all outputs 0, state IDLE.
